// File: rtl/keypad_emulator.sv
// 4x4 matrix-keypad model: answers a column scan with a row pull-down while an emulated key is held.
// Define KEYPAD_EMU_BOUNCE_EN to compile in contact bounce on press and release.
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 50000,
  parameter int BOUNCE_CYCLES = 2000,
  parameter int BOUNCE_STEP   = 250,
  parameter int GAP_CYCLES    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  input  logic [3:0] key,
  input  logic       key_valid,
  output logic       key_ready,
  output logic [3:0] rows,
  output logic       pressed,
  output logic       done,
  output logic [2:0] dbg_state
);

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_BS = (BOUNCE_CYCLES > BOUNCE_STEP) ? BOUNCE_CYCLES : BOUNCE_STEP;
  localparam int MAX_P  = (MAX_HG > MAX_BS) ? MAX_HG : MAX_BS;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESS_BOUNCE   = 3'd1,
    HOLD           = 3'd2,
    RELEASE_BOUNCE = 3'd3,
    GAP            = 3'd4
  } state_t;

  // Handshake: a request is taken on any rising edge where key_valid and
  // key_ready are both high; key_ready is high only in IDLE and nothing is buffered.
  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          contact, contact_n;
  logic          done_n;
  logic          key_en;
  logic          cnt_clr;
  logic [3:0]    key_q;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [CW-1:0] BOUNCE_LAST = CW'(BOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST   = CW'(BOUNCE_STEP - 1);

  logic [CW-1:0] step;
  logic          bouncing;
  logic          step_hit;

  assign bouncing = (state == PRESS_BOUNCE) || (state == RELEASE_BOUNCE);
  assign step_hit = (step == STEP_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step <= '0;
    end else if (cnt_clr || step_hit || !bouncing) begin
      step <= '0;
    end else begin
      step <= step + CW'(1);
    end
  end
`endif

  always_comb begin
    state_n   = state;
    contact_n = contact;
    done_n    = 1'b0;
    key_en    = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (key_valid) begin
          key_en    = 1'b1;
          cnt_clr   = 1'b1;
          contact_n = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_n   = PRESS_BOUNCE;
`else
          state_n   = HOLD;
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      PRESS_BOUNCE: begin
        if (cnt == BOUNCE_LAST) begin
          state_n   = HOLD;
          contact_n = 1'b1;
          cnt_clr   = 1'b1;
        end else if (step_hit) begin
          contact_n = ~contact;
        end
      end
`endif
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          contact_n = 1'b0;
          cnt_clr   = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_n   = RELEASE_BOUNCE;
`else
          state_n   = GAP;
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      RELEASE_BOUNCE: begin
        if (cnt == BOUNCE_LAST) begin
          state_n   = GAP;
          contact_n = 1'b0;
          cnt_clr   = 1'b1;
        end else if (step_hit) begin
          contact_n = ~contact;
        end
      end
`endif
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_n   = IDLE;
        contact_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      contact <= 1'b0;
      done    <= 1'b0;
      key_q   <= 4'h0;
    end else begin
      state   <= state_n;
      contact <= contact_n;
      done    <= done_n;
      if (key_en) key_q <= key;
      if (cnt_clr || state == IDLE) cnt <= '0;
      else cnt <= cnt + CW'(1);
    end
  end

  // The switch itself: a closed contact shorts the selected column onto its row.
  always_comb begin
    rows = 4'hF;
    if (contact && !cols[key_q[1:0]]) rows[key_q[3:2]] = 1'b0;
  end

  assign key_ready = (state == IDLE);
  assign pressed   = contact;
  assign dbg_state = state;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: the driver pushes per-cycle expected {done,pressed,rows}
// on each accepted press, a negedge monitor pops and compares while the emulator is busy.
module tb_keypad_emulator;

  localparam int HOLD   = 8;
  localparam int BOUNCE = 6;
  localparam int STEP   = 2;
  localparam int GAP    = 4;

`ifdef KEYPAD_EMU_BOUNCE_EN
  // press bounce 110011, hold 8x1, release bounce 001100, gap 0000, done cycle 0
  localparam int          LAT      = 25;
  localparam logic [24:0] PAT      = 25'b110011_11111111_001100_0000_0;
  localparam int          HOLD_OFS = 9;
`else
  // hold 8x1, gap 0000, done cycle 0
  localparam int          LAT      = 13;
  localparam logic [24:0] PAT      = 25'b000000000000_11111111_0000_0;
  localparam int          HOLD_OFS = 3;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] cols;
  logic [3:0] key;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] rows;
  logic       pressed;
  logic       done;
  logic [2:0] dbg_state;

  logic [5:0] exp_q[$];
  int         done_q[$];
  int         n_checks;
  int         n_errors;
  int         cyc;

  keypad_emulator #(
    .HOLD_CYCLES  (HOLD),
    .BOUNCE_CYCLES(BOUNCE),
    .BOUNCE_STEP  (STEP),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cols     (cols),
    .key      (key),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .rows     (rows),
    .pressed  (pressed),
    .done     (done),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_press(input int acc, input logic [3:0] rows_closed);
    logic [24:0] p;
    logic        b;
    p = PAT;
    for (int i = 0; i < LAT; i++) begin
      b = p[LAT-1-i];
      exp_q.push_back({(i == LAT - 1), b, (b ? rows_closed : 4'hF)});
    end
    done_q.push_back(acc + LAT - 1);
  endtask

  // driver: returns with acc = number of the first cycle after the accepting edge
  task automatic send(input logic [3:0] k, input logic [3:0] rows_closed, output int acc);
    int n;
    @(negedge clk);
    key       = k;
    key_valid = 1'b1;
    n = 0;
    while (!key_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!key_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: key_ready still %0b after %0d cycles, required 1", key_ready, n);
      key_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key       = 4'($urandom_range(0, 15));
    acc       = cyc;
    push_press(acc, rows_closed);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
    done_q.delete();
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [5:0] e;
    if (reset && (!key_ready || done)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got done=%0b pressed=%0b rows=%0h with nothing expected",
                 done, pressed, rows);
      end else begin
        e = exp_q.pop_front();
        check("seq_done_pressed_rows", {26'd0, done, pressed, rows}, {26'd0, e});
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, required none", cyc);
        end else begin
          check("done_cycle", cyc, done_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int a1;
    int a2;
    int nd;
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    cols      = 4'hF;
    key       = 4'h0;
    key_valid = 1'b0;

    // reset state
    #1;
    check("rst_key_ready", key_ready, 1);
    check("rst_rows", rows, 4'hF);
    check("rst_pressed", pressed, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // basic press: row 1, col 2
    cols = 4'b1011;
    send(4'b0110, 4'b1101, a);
    wait_drain("basic_drain");

    // column mismatch: contact still runs, rows never pulled
    cols = 4'b1101;
    send(4'b0110, 4'hF, a);
    wait_drain("mismatch_drain");

    // key 0 on col 0
    cols = 4'b1110;
    send(4'b0000, 4'b1110, a);
    wait_drain("key0_drain");

    // handshake: second request raised mid-HOLD is held off until the done cycle
    cols = 4'b1011;
    send(4'b0110, 4'b1101, a1);
    repeat (HOLD_OFS) @(negedge clk);
    check("hs_first_in_hold", pressed, 1);
    send(4'hF, 4'b0111, a2);
    check("hs_accept_on_done", a2, a1 + LAT);
    #1;
    cols = 4'b1111;
    #1;
    check("comb_cols_open", rows, 4'hF);
    cols = 4'b0110;
    #1;
    check("comb_multi_low", rows, 4'b0111);
    cols = 4'b0111;
    wait_drain("hs_drain");

    // asynchronous reset mid-HOLD
    cols = 4'b1011;
    send(4'b0110, 4'b1101, a);
    repeat (HOLD_OFS) @(posedge clk);
    #3;
    check("pre_rst_pressed", pressed, 1);
    check("pre_rst_rows", rows, 4'b1101);
    reset = 1'b0;
    exp_q.delete();
    done_q.delete();
    #1;
    check("mid_rst_rows", rows, 4'hF);
    check("mid_rst_ready", key_ready, 1);
    check("mid_rst_pressed", pressed, 0);
    check("mid_rst_state", dbg_state, 0);
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("no_done_after_rst", nd, 0);

    // recovery press after reset
    cols = 4'b1110;
    send(4'b0000, 4'b1110, a);
    wait_drain("recover_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
